// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, debounce filter and press detect for one button
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; clears synchroniser, debounce state and press history
//   raw    - raw button level, asynchronous to clock
//   level  - debounced button level
//   press  - high for one cycle on each debounced rising edge of level
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_0;
  logic             sync_1;
  logic             db;
  logic             db_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_0 <= 1'b0;
      sync_1 <= 1'b0;
      db     <= 1'b0;
      db_d   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_0 <= raw;
      sync_1 <= sync_0;
      db_d   <= db;
      // cnt counts consecutive cycles of disagreement; any agreement restarts it,
      // so a pulse shorter than DEBOUNCE_CYCLES never reaches the terminal value.
      if (sync_1 != db) begin
        if (cnt == CNT_LAST) begin
          db  <= sync_1;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level = db;
  assign press = db & ~db_d;

endmodule

// File: rtl/counter_enable_ctrl.sv
// rtl/counter_enable_ctrl.sv - run/idle enable generator for the 4-bit counter
//
// Ports:
//   clock     - rising-edge clock
//   reset     - synchronous, active-high; aborts a run at the edge it is seen
//   button_in - raw start/stop button
//   step_in   - raw single-step button
//   enable    - registered one-cycle enable tick to the counter
//   running   - registered, high while the FSM is in RUN
module counter_enable_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE        = 4,
  parameter int CNT_W           = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  input  logic step_in,
  output logic enable,
  output logic running
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] PRESCALE_LAST = CNT_W'(PRESCALE - 1);

  logic start_press;
  logic step_press;
  logic start_level;
  logic step_level;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             enable_next;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_start_db (
    .clock(clock),
    .reset(reset),
    .raw  (button_in),
    .level(start_level),
    .press(start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_step_db (
    .clock(clock),
    .reset(reset),
    .raw  (step_in),
    .level(step_level),
    .press(step_press)
  );

  // Only the press edges drive the FSM; the levels are not needed here.
  logic unused_levels;
  assign unused_levels = start_level ^ step_level;

  always_comb begin
    state_next  = state;
    count_next  = count;
    enable_next = 1'b0;
    case (state)
      IDLE: begin
        // start/stop has priority; a coincident step press is dropped, not queued
        if (start_press) begin
          state_next = RUN;
          count_next = '0;
        end else if (step_press) begin
          enable_next = 1'b1;
        end
      end
      RUN: begin
        // stopping takes precedence over a tick that would be due this edge
        if (start_press) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count == PRESCALE_LAST) begin
          count_next  = '0;
          enable_next = 1'b1;
        end else begin
          count_next = count + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      enable <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      enable <= enable_next;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_counter_enable_ctrl.sv
// tb/tb_counter_enable_ctrl.sv - scoreboard bench for counter_enable_ctrl (default and PRESCALE=1 instances)
module tb_counter_enable_ctrl;

  logic clock = 1'b0;
  logic reset;
  logic button_in;
  logic step_in;
  logic enable;
  logic running;
  logic enable_p1;
  logic running_p1;

  always #5 clock = ~clock;

  counter_enable_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .button_in(button_in),
    .step_in  (step_in),
    .enable   (enable),
    .running  (running)
  );

  counter_enable_ctrl #(.PRESCALE(1)) dut_p1 (
    .clock    (clock),
    .reset    (reset),
    .button_in(button_in),
    .step_in  (step_in),
    .enable   (enable_p1),
    .running  (running_p1)
  );

  // expected {enable, running, enable_p1, running_p1} after each edge
  logic [3:0] exp_q[$];
  int         edge_q[$];
  string      name_q[$];

  int checks = 0;
  int passed = 0;
  int ds_count = 0;

  logic [3:0] mon_exp;
  int         mon_edge;
  string      mon_name;

  task automatic check_val(input string nm, input int edge_no, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s edge %0d: got %0d expected %0d", nm, edge_no, got, exp);
  endtask

  task automatic check_bit(input string nm, input int edge_no, input logic got, input logic exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s edge %0d: got %b expected %b", nm, edge_no, got, exp);
  endtask

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (enable === 1'b1) ds_count++;
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_edge = edge_q.pop_front();
      mon_name = name_q.pop_front();
      check_bit({mon_name, ".enable"},     mon_edge, enable,     mon_exp[3]);
      check_bit({mon_name, ".running"},    mon_edge, running,    mon_exp[2]);
      check_bit({mon_name, ".enable_p1"},  mon_edge, enable_p1,  mon_exp[1]);
      check_bit({mon_name, ".running_p1"}, mon_edge, running_p1, mon_exp[0]);
    end
  end

  // drive inputs for one edge and queue the expected outputs after that edge
  task automatic cyc(input string nm, input int k, input logic r, input logic b, input logic s,
                     input logic en, input logic run, input logic en1);
    reset     = r;
    button_in = b;
    step_in   = s;
    @(posedge clock);
    exp_q.push_back({en, run, en1, run});
    edge_q.push_back(k);
    name_q.push_back(nm);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic b, s, r, en, run, en1;
    int   ds_before;
    int   wait_cnt;

    // reset, then idle with buttons low
    for (int k = 1; k <= 2; k++) cyc("reset", k, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 50; k++) cyc("idle", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // start at edge 7, ticks 11,15,...,35; stop press reacts at 39 where a tick was due
    for (int k = 1; k <= 60; k++) begin
      b   = (k <= 10) || (k >= 33 && k <= 42);
      run = (k >= 7) && (k < 39);
      en  = run && (k >= 11) && ((k - 11) % 4 == 0);
      en1 = (k >= 8) && (k < 39);
      cyc("start_stop", k, 1'b0, b, 1'b0, en, run, en1);
    end

    // 3-cycle glitch is rejected
    for (int k = 1; k <= 20; k++) begin
      b = (k <= 3);
      cyc("glitch", k, 1'b0, b, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // five single steps, one tick each at edge 7
    @(negedge clock); #1;
    ds_before = ds_count;
    for (int rep = 0; rep < 5; rep++) begin
      for (int k = 1; k <= 20; k++) begin
        s  = (k <= 8);
        en = (k == 7);
        cyc("step", k, 1'b0, 1'b0, s, en, 1'b0, en);
      end
    end
    @(negedge clock); #1;
    check_val("step_count", 0, ds_count - ds_before, 5);

    // step press at 20 during RUN ignored; reset at 31 aborts a due tick
    for (int k = 1; k <= 40; k++) begin
      b   = (k <= 10);
      s   = (k >= 14) && (k <= 21);
      r   = (k == 31);
      run = (k >= 7) && (k < 31);
      en  = run && (k >= 11) && ((k - 11) % 4 == 0);
      en1 = (k >= 8) && (k < 31);
      cyc("run_step_reset", k, r, b, s, en, run, en1);
    end

    // simultaneous press enters RUN without a step tick; then button held through reset
    for (int k = 1; k <= 45; k++) begin
      b   = (k <= 10) || (k >= 21);
      s   = (k <= 10);
      r   = (k == 21) || (k == 22);
      run = ((k >= 7) && (k < 21)) || (k >= 29);
      en  = ((k >= 11) && (k < 21) && ((k - 11) % 4 == 0)) || ((k >= 33) && ((k - 33) % 4 == 0));
      en1 = ((k >= 8) && (k < 21)) || (k >= 30);
      cyc("simul_held", k, r, b, s, en, run, en1);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clock);
      wait_cnt++;
    end
    check_val("drain", 0, exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
